// File: rtl/i2s_rx_deser.sv
// i2s_rx_deser: slave I2S receiver, MSB-first with one-bit delay, emits L/R pairs plus valid/err pulses.
module i2s_rx_deser #(
  parameter int MAXW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            frame_32_i,
  input  logic            ws_i,
  input  logic            sd_i,
  output logic [MAXW-1:0] data_l_o,
  output logic [MAXW-1:0] data_r_o,
  output logic            valid_o,
  output logic            err_o
);
  typedef enum logic {SYNC, RUN} state_t;
  state_t      state_q, state_d;
  logic        ws_q, n32_q, n32_d, have_left_q, have_left_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic [5:0]  cnt_q, cnt_d, nm1;
  logic [31:0] word_q, word_d, hold_q, hold_d, dl_q, dl_d, dr_q, dr_d, cap;
  logic        bnd;
  always_comb begin
    bnd = ws_i != ws_q;
    nm1 = n32_q ? 6'd31 : 6'd15;
    cap = word_q;
    if (cnt_q <= nm1) cap[5'(nm1 - cnt_q)] = sd_i;
    state_d     = state_q;
    cnt_d       = bnd ? 6'd0 : (cnt_q == 6'd63 ? cnt_q : cnt_q + 6'd1);
    n32_d       = bnd ? frame_32_i : n32_q;
    word_d      = word_q;
    hold_d      = hold_q;
    have_left_d = have_left_q;
    dl_d        = dl_q;
    dr_d        = dr_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    if (!en_i) begin
      state_d = SYNC;
    end else if (state_q == SYNC) begin
      if (bnd) begin
        state_d     = RUN;
        have_left_d = 1'b0;
        word_d      = '0;
      end
    end else begin
      // the boundary-edge bit is the LSB of the word that is ending
      word_d = bnd ? '0 : cap;
      if (bnd) begin
        err_d = cnt_q != nm1;
        if (!ws_q) begin
          hold_d      = cap;
          have_left_d = 1'b1;
        end else begin
          have_left_d = 1'b0;
          valid_d     = have_left_q;
          dl_d        = have_left_q ? hold_q : dl_q;
          dr_d        = have_left_q ? cap : dr_q;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SYNC;
      ws_q        <= 1'b1;
      cnt_q       <= '0;
      n32_q       <= 1'b1;
      word_q      <= '0;
      hold_q      <= '0;
      have_left_q <= 1'b0;
      dl_q        <= '0;
      dr_q        <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_q        <= ws_i;
      cnt_q       <= cnt_d;
      n32_q       <= n32_d;
      word_q      <= word_d;
      hold_q      <= hold_d;
      have_left_q <= have_left_d;
      dl_q        <= dl_d;
      dr_q        <= dr_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end
  assign data_l_o = MAXW'(dl_q);
  assign data_r_o = MAXW'(dr_q);
  assign valid_o  = valid_q;
  assign err_o    = err_q;
endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb_i2s_rx_deser: directed I2S streams with hand-computed L/R words, pulse counts and error flags.
module tb_i2s_rx_deser;
  logic        clk = 1'b0, rst_n = 1'b1, en = 1'b1, frame_32 = 1'b1, ws = 1'b1, sd = 1'b0;
  logic [31:0] dl, dr;
  logic        valid, err;
  int          tests = 0, fails = 0, n_valid = 0, n_err = 0;

  i2s_rx_deser #(.MAXW(32)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .frame_32_i(frame_32), .ws_i(ws), .sd_i(sd),
    .data_l_o(dl), .data_r_o(dr), .valid_o(valid), .err_o(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) n_valid++;
    if (err) n_err++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // k-1 bits on channel ch, then the LSB on the edge where ws flips
  task automatic send_word(input logic ch, input logic [63:0] bits, input int k);
    for (int i = k - 1; i >= 1; i--) begin
      ws = ch;
      sd = bits[i];
      tick();
    end
    ws = ~ch;
    sd = bits[0];
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_dl", 64'(dl), 0);
    check("rst_dr", 64'(dr), 0);
    check("rst_valid", 64'(valid), 0);
    check("rst_err", 64'(err), 0);
    rst_n = 1'b1;
    send_word(1'b1, 64'h155, 10);
    check("t5_sync_valid", 64'(valid), 0);
    check("t5_sync_err", 64'(err), 0);
    send_word(1'b0, 64'hDEADBEEF, 32);
    check("t1_err_l", 64'(err), 0);
    check("t1_novalid_l", 64'(valid), 0);
    send_word(1'b1, 64'h12345678, 32);
    check("t1_valid", 64'(valid), 1);
    check("t1_dl", 64'(dl), 64'hDEADBEEF);
    check("t1_dr", 64'(dr), 64'h12345678);
    check("t1_err", 64'(err), 0);
    en = 1'b0;
    repeat (2) tick();
    check("t1_valid_pulses", 64'(n_valid), 1);
    check("t1_valid_low", 64'(valid), 0);
    frame_32 = 1'b0;
    en = 1'b1;
    send_word(1'b0, 64'h0, 16);
    send_word(1'b1, 64'h0, 16);
    check("t2_lone_right_valid", 64'(valid), 0);
    check("t2_lone_right_err", 64'(err), 0);
    send_word(1'b0, 64'hA5A5, 16);
    send_word(1'b1, 64'h5A5A, 16);
    check("t2_valid", 64'(valid), 1);
    check("t2_dl", 64'(dl), 64'h0000A5A5);
    check("t2_dr", 64'(dr), 64'h00005A5A);
    check("t2_err", 64'(err), 0);
    en = 1'b0;
    tick();
    check("t2_valid_pulses", 64'(n_valid), 2);
    check("t2_err_pulses", 64'(n_err), 0);
    frame_32 = 1'b1;
    en = 1'b1;
    send_word(1'b0, 64'h0, 32);
    send_word(1'b1, 64'h0, 32);
    send_word(1'b0, 64'h3FFFFFFF, 30);
    check("t3_short_err", 64'(err), 1);
    check("t3_short_novalid", 64'(valid), 0);
    send_word(1'b1, 64'h0, 32);
    check("t3_valid", 64'(valid), 1);
    check("t3_err_r", 64'(err), 0);
    check("t3_dl", 64'(dl), 64'hFFFFFFFC);
    check("t3_dr", 64'(dr), 64'h0);
    send_word(1'b0, 64'h11111111, 32);
    check("t4_err_l", 64'(err), 0);
    send_word(1'b1, {30'h0, 32'hCAFEF00D, 2'b11}, 34);
    check("t4_err", 64'(err), 1);
    check("t4_valid", 64'(valid), 1);
    check("t4_dl", 64'(dl), 64'h11111111);
    check("t4_dr", 64'(dr), 64'hCAFEF00D);
    for (int i = 0; i < 10; i++) begin
      ws = 1'b0;
      sd = 1'b1;
      tick();
    end
    en = 1'b0;
    repeat (3) tick();
    check("t6_en_valid", 64'(valid), 0);
    check("t6_en_err", 64'(err), 0);
    check("t6_en_dl_hold", 64'(dl), 64'h11111111);
    check("t6_en_dr_hold", 64'(dr), 64'hCAFEF00D);
    check("t6_en_valid_pulses", 64'(n_valid), 4);
    check("t6_en_err_pulses", 64'(n_err), 2);
    en = 1'b1;
    send_word(1'b0, 64'h0, 22);
    check("t6_resync_err", 64'(err), 0);
    send_word(1'b1, 64'hFFFF, 32);
    check("t6_lone_right_valid", 64'(valid), 0);
    send_word(1'b0, 64'h0BADCAFE, 32);
    send_word(1'b1, 64'h600DD00D, 32);
    check("t6_valid", 64'(valid), 1);
    check("t6_dl", 64'(dl), 64'h0BADCAFE);
    check("t6_dr", 64'(dr), 64'h600DD00D);
    for (int i = 0; i < 5; i++) begin
      ws = 1'b0;
      sd = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("t6_rst_dl", 64'(dl), 0);
    check("t6_rst_dr", 64'(dr), 0);
    check("t6_rst_valid", 64'(valid), 0);
    check("t6_rst_err", 64'(err), 0);
    ws = 1'b1;
    tick();
    rst_n = 1'b1;
    send_word(1'b1, 64'hFFFFFFFF, 32);
    check("t6_rst_sync_valid", 64'(valid), 0);
    send_word(1'b0, 64'h13579BDF, 32);
    send_word(1'b1, 64'h2468ACE0, 32);
    check("t6_rst_valid_pair", 64'(valid), 1);
    check("t6_rst_dl_pair", 64'(dl), 64'h13579BDF);
    check("t6_rst_dr_pair", 64'(dr), 64'h2468ACE0);
    tick();
    check("final_valid_pulses", 64'(n_valid), 6);
    check("final_err_pulses", 64'(n_err), 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
